// File: rtl/l2_req_arbiter_pkg.sv
// Shared types and constants for the L2 request arbiter and its L2 port.
package l2_req_arbiter_pkg;

  // Address/data width of the L2 port; the arbiter default tracks it.
  localparam int unsigned WORD_SIZE = 32;

  // Mirrors the L2 internal cycle bit: address-latch edge next, or execute edge next.
  typedef enum logic {
    PhAddr = 1'b0,
    PhExec = 1'b1
  } l2_phase_e;

  // One L2 operation as presented on the L2 port.
  typedef struct packed {
    logic                 wr;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
  } l2_req_t;

  // One L2 result as returned by the L2 port.
  typedef struct packed {
    logic                 hit;
    logic [WORD_SIZE-1:0] data;
  } l2_rsp_t;

endpackage

// File: rtl/l2_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]                       i_req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_ptr,
  output logic [N-1:0]                       o_gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] o_idx,
  output logic                               o_any
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [31:0] w_cand;

  // Scan N candidates starting at the pointer, wrapping N-1 -> 0.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = 32'(i_ptr) + 32'(k);
      if (w_cand >= 32'(N)) begin
        w_cand = w_cand - 32'(N);
      end
      if (!o_any && i_req[w_cand[W-1:0]]) begin
        o_any                = 1'b1;
        o_gnt[w_cand[W-1:0]] = 1'b1;
        o_idx                = w_cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Shares one two-phase L2 port between NUM_REQ requesters with round-robin grants.
// One op may start every 2 cycles; responses return 3 cycles after the grant, in order.
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned WORD_SIZE = l2_req_arbiter_pkg::WORD_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [NUM_REQ-1:0]           i_req_wr,
  input  logic [NUM_REQ*WORD_SIZE-1:0] i_req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic                         o_rsp_hit,
  output logic [WORD_SIZE-1:0]         o_rsp_data,
  output logic                         o_l2_wr_en,
  output logic [WORD_SIZE-1:0]         o_l2_addr,
  output logic [WORD_SIZE-1:0]         o_l2_data,
  input  logic [WORD_SIZE-1:0]         i_l2_data_out,
  input  logic                         i_l2_hit_or_miss
);

  localparam int unsigned      REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [REQ_W-1:0] LastIdx = REQ_W'(NUM_REQ - 1);

  l2_phase_e r_ph, w_ph_next;

  logic [REQ_W-1:0]     r_rr;
  logic                 r_vld;
  logic [REQ_W-1:0]     r_own;
  logic                 r_wr;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_data;
  logic                 r_rvld;
  logic [REQ_W-1:0]     r_rown;

  logic [NUM_REQ-1:0]   w_req_elig;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [REQ_W-1:0]     w_gnt_idx;
  logic                 w_gnt_any;
  logic                 w_sel_wr;
  logic [WORD_SIZE-1:0] w_sel_addr;
  logic [WORD_SIZE-1:0] w_sel_data;

  // Phase register; shares rst with the L2 so both cycle bits stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph <= PhAddr;
    end else begin
      r_ph <= w_ph_next;
    end
  end

  // Phase simply alternates every cycle.
  always_comb begin
    w_ph_next = PhAddr;
    case (r_ph)
      PhAddr:  w_ph_next = PhExec;
      PhExec:  w_ph_next = PhAddr;
      default: w_ph_next = PhAddr;
    endcase
  end

  // Requests are only eligible in the cycle before the L2 execute edge.
  assign w_req_elig = (r_ph == PhExec) ? i_req_valid : '0;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .i_req(w_req_elig),
    .i_ptr(r_rr),
    .o_gnt(w_gnt),
    .o_idx(w_gnt_idx),
    .o_any(w_gnt_any)
  );

  assign o_req_ready = w_gnt;

  // Route the winner's request fields; the grant is one-hot so at most one slot matches.
  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_wr   = i_req_wr[i];
        w_sel_addr = i_req_addr[i*WORD_SIZE +: WORD_SIZE];
        w_sel_data = i_req_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Issue stage, response stage and rr pointer all advance on the execute edge.
  // The old issue wr_en/data are what the L2 consumes on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr   <= '0;
      r_vld  <= 1'b0;
      r_own  <= '0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_rvld <= 1'b0;
      r_rown <= '0;
    end else if (r_ph == PhExec) begin
      r_vld  <= w_gnt_any;
      r_own  <= w_gnt_idx;
      r_rvld <= r_vld;
      r_rown <= r_own;
      if (w_gnt_any) begin
        r_wr   <= w_sel_wr;
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
        r_rr   <= (w_gnt_idx == LastIdx) ? '0 : w_gnt_idx + REQ_W'(1);
      end else begin
        // Idle slot: never leave a stale write enabled; addr/data hold.
        r_wr <= 1'b0;
      end
    end else begin
      r_rvld <= 1'b0;
    end
  end

  assign o_l2_wr_en = r_wr;
  assign o_l2_addr  = r_addr;
  assign o_l2_data  = r_data;

  // Response pulse to the owner in the cycle after the execute edge.
  always_comb begin
    o_rsp_valid = '0;
    if (r_rvld && (r_ph == PhAddr)) begin
      o_rsp_valid[r_rown] = 1'b1;
    end
  end

  // L2 result passes straight through; rsp_valid alone qualifies it.
  assign o_rsp_hit  = i_l2_hit_or_miss;
  assign o_rsp_data = i_l2_data_out;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Bench for l2_req_arbiter with a behavioural 4-way L2 on the port.
`timescale 1ns/1ps
module tb_l2_req_arbiter;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic [1:0]  i_req_wr;
  logic [63:0] i_req_addr;
  logic [63:0] i_req_data;
  logic [1:0]  o_rsp_valid;
  logic        o_rsp_hit;
  logic [31:0] o_rsp_data;
  logic        o_l2_wr_en;
  logic [31:0] o_l2_addr;
  logic [31:0] o_l2_data;
  logic [31:0] l2_dout;
  logic        l2_hit;

  always #5 clk = ~clk;

  l2_req_arbiter #(
    .NUM_REQ(2),
    .WORD_SIZE(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_wr(i_req_wr),
    .i_req_addr(i_req_addr),
    .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_hit(o_rsp_hit),
    .o_rsp_data(o_rsp_data),
    .o_l2_wr_en(o_l2_wr_en),
    .o_l2_addr(o_l2_addr),
    .o_l2_data(o_l2_data),
    .i_l2_data_out(l2_dout),
    .i_l2_hit_or_miss(l2_hit)
  );

  // ---------------- behavioural L2: 16 sets x 4 ways, addr latch then execute ----------------
  logic        m_v   [16][4];
  logic [25:0] m_tag [16][4];
  logic [31:0] m_dat [16][4];
  logic        l2_c;
  logic [31:0] l2_lat;
  logic [3:0]  l2_idx;
  logic [25:0] l2_tag;
  assign l2_idx = l2_lat[5:2];
  assign l2_tag = l2_lat[31:6];

  function automatic int find_way(logic [3:0] s, logic [25:0] t);
    for (int w = 0; w < 4; w++) if (m_v[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int free_way(logic [3:0] s);
    for (int w = 0; w < 4; w++) if (!m_v[s][w]) return w;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      l2_c    <= 1'b0;
      l2_lat  <= '0;
      l2_hit  <= 1'b0;
      l2_dout <= '0;
      for (int s = 0; s < 16; s++) for (int w = 0; w < 4; w++) m_v[s][w] <= 1'b0;
    end else begin
      l2_c <= ~l2_c;
      if (!l2_c) begin
        l2_lat <= o_l2_addr;
      end else if (o_l2_wr_en) begin
        l2_hit  <= 1'b1;
        l2_dout <= o_l2_data;
        if (find_way(l2_idx, l2_tag) >= 0) begin
          m_dat[l2_idx][find_way(l2_idx, l2_tag)] <= o_l2_data;
        end else if (free_way(l2_idx) >= 0) begin
          m_v[l2_idx][free_way(l2_idx)]   <= 1'b1;
          m_tag[l2_idx][free_way(l2_idx)] <= l2_tag;
          m_dat[l2_idx][free_way(l2_idx)] <= o_l2_data;
        end
      end else if (find_way(l2_idx, l2_tag) >= 0) begin
        l2_hit  <= 1'b1;
        l2_dout <= m_dat[l2_idx][find_way(l2_idx, l2_tag)];
      end else begin
        l2_hit  <= 1'b0;
        l2_dout <= '0;
      end
    end
  end

  // ---------------- bench state ----------------
  typedef struct {
    int          r;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_hit;
    logic [31:0] exp_data;
    int          batch;
  } vec_t;

  typedef struct {
    int          r;
    logic        hit;
    logic [31:0] data;
    int          due;
  } exp_t;

  vec_t        vecs [NV];
  vec_t        q0[$];
  vec_t        q1[$];
  exp_t        sb[$];
  int          gnt_log[$];
  int          gnt_cyc[$];
  int          last_gnt_cyc [2];
  int          n_gnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc;
  logic [1:0]  hs = 2'b00;

  // Cycle index since reset release; cycle 0 is the first ph==0 cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t front(int r);
    if (r == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic push_vec(input vec_t v);
    if (v.r == 0) q0.push_back(v);
    else          q1.push_back(v);
  endtask

  task automatic drive(input int r);
    vec_t v;
    logic have;
    have = (r == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      v                        = front(r);
      i_req_valid[r[0]]        = 1'b1;
      i_req_wr[r[0]]           = v.wr;
      i_req_addr[r*32 +: 32]   = v.addr;
      i_req_data[r*32 +: 32]   = v.data;
    end else begin
      i_req_valid[r[0]] = 1'b0;
    end
  endtask

  // Driver: retire handshaken items, then present each requester's queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hs[0]) begin void'(q0.pop_front()); hs[0] = 1'b0; end
      if (hs[1]) begin void'(q1.pop_front()); hs[1] = 1'b0; end
      drive(0);
      drive(1);
    end
  end

  // Monitor/scoreboard, sampled on the falling edge.
  initial begin
    int          rr_m;
    int          gr;
    int          c;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    exp_t        e;
    vec_t        v;
    rr_m = 0; e_wr = 1'b0; e_addr = '0; e_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rr_m = 0; e_wr = 1'b0; e_addr = '0; e_data = '0; hs = 2'b00;
      end else begin
        chk("l2_wr_en", 64'(o_l2_wr_en), 64'(e_wr));
        chk("l2_addr", 64'(o_l2_addr), 64'(e_addr));
        chk("l2_data", 64'(o_l2_data), 64'(e_data));
        exp_gnt = 2'b00;
        gr      = -1;
        if (cyc % 2 == 1) begin
          for (int k = 0; k < 2; k++) begin
            c = (rr_m + k) % 2;
            if (gr < 0 && i_req_valid[c[0]]) begin
              gr             = c;
              exp_gnt[c[0]]  = 1'b1;
            end
          end
        end
        chk("req_ready", 64'(o_req_ready), 64'(exp_gnt));
        if (sb.size() > 0 && sb[0].due == cyc) begin
          e              = sb.pop_front();
          exp_rv         = 2'b00;
          exp_rv[e.r[0]] = 1'b1;
          chk("rsp_valid", 64'(o_rsp_valid), 64'(exp_rv));
          chk("rsp_hit", 64'(o_rsp_hit), 64'(e.hit));
          chk("rsp_data", 64'(o_rsp_data), 64'(e.data));
        end else begin
          chk("rsp_valid_idle", 64'(o_rsp_valid), 64'd0);
        end
        if (gr >= 0 && ((gr == 0) ? (q0.size() > 0) : (q1.size() > 0))) begin
          v = front(gr);
          sb.push_back('{gr, v.exp_hit, v.exp_data, cyc + 3});
          hs[gr[0]]        = 1'b1;
          e_wr             = v.wr;
          e_addr           = v.addr;
          e_data           = v.data;
          rr_m             = (gr + 1) % 2;
          last_gnt_cyc[gr] = cyc;
          gnt_log.push_back(gr);
          gnt_cyc.push_back(cyc);
          n_gnt++;
        end else if (cyc % 2 == 1) begin
          e_wr = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (q0.size() > 0 || q1.size() > 0 || sb.size() > 0) begin
      n_fail++;
      $display("FAIL %s: drain timeout, pending q0=%0d q1=%0d sb=%0d required 0",
               name, q0.size(), q1.size(), sb.size());
      q0.delete(); q1.delete(); sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ready"}, 64'(o_req_ready), 64'd0);
    chk({name, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    chk({name, "_l2_wr_en"}, 64'(o_l2_wr_en), 64'd0);
    chk({name, "_l2_addr"}, 64'(o_l2_addr), 64'd0);
    chk({name, "_l2_data"}, 64'(o_l2_data), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    int   n0;
    int   raise_cyc;
    vec_t v;

    // {req, wr, addr, data, exp_hit, exp_data, batch}
    vecs[0]  = '{0, 1'b0, 32'h1000_0040, 32'h0,         1'b0, 32'h0,         0};
    vecs[1]  = '{1, 1'b1, 32'h1234_5670, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[2]  = '{1, 1'b0, 32'h1234_5670, 32'h0,         1'b1, 32'hDEAD_BEEF, 1};
    vecs[3]  = '{0, 1'b1, 32'h0000_100C, 32'h1111_1111, 1'b1, 32'h1111_1111, 2};
    vecs[4]  = '{1, 1'b1, 32'h0000_200C, 32'h2222_2222, 1'b1, 32'h2222_2222, 2};
    vecs[5]  = '{0, 1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h1111_1111, 2};
    vecs[6]  = '{1, 1'b0, 32'h0000_300C, 32'h0,         1'b0, 32'h0,         2};
    vecs[7]  = '{0, 1'b1, 32'hA000_0014, 32'h0A0A_0A0A, 1'b1, 32'h0A0A_0A0A, 3};
    vecs[8]  = '{0, 1'b1, 32'hB000_0014, 32'h0B0B_0B0B, 1'b1, 32'h0B0B_0B0B, 3};
    vecs[9]  = '{0, 1'b1, 32'hC000_0014, 32'h0C0C_0C0C, 1'b1, 32'h0C0C_0C0C, 3};
    vecs[10] = '{0, 1'b1, 32'hD000_0014, 32'h0D0D_0D0D, 1'b1, 32'h0D0D_0D0D, 3};
    vecs[11] = '{0, 1'b1, 32'hE000_0014, 32'h0E0E_0E0E, 1'b1, 32'h0E0E_0E0E, 3};
    vecs[12] = '{0, 1'b0, 32'hE000_0014, 32'h0,         1'b0, 32'h0,         3};
    vecs[13] = '{0, 1'b0, 32'hA000_0014, 32'h0,         1'b1, 32'h0A0A_0A0A, 3};

    rst         = 1'b1;
    i_req_valid = '0;
    i_req_wr    = '0;
    i_req_addr  = '0;
    i_req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    for (int i = 0; i < NV; i++) begin
      push_vec(vecs[i]);
      if (i == NV - 1 || vecs[i + 1].batch != vecs[i].batch) begin
        if (vecs[i].batch == 0) begin
          // Request is already valid when reset releases, i.e. from cycle 0.
          @(posedge clk);
          #2;
          rst = 1'b0;
        end
        wait_drain($sformatf("batch%0d", vecs[i].batch), 60);
        if (vecs[i].batch == 0) begin
          chk("t1_grant_cycle", 64'(last_gnt_cyc[0]), 64'd1);
        end
        if (vecs[i].batch == 2) begin
          chk("t3_grant_count", 64'(gnt_log.size()), 64'd4);
          if (gnt_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
              chk($sformatf("t3_grant_order%0d", k), 64'(gnt_log[k]), 64'(k % 2));
              if (k > 0) chk($sformatf("t3_grant_gap%0d", k),
                             64'(gnt_cyc[k] - gnt_cyc[k - 1]), 64'd2);
            end
          end
        end
        gnt_log.delete();
        gnt_cyc.delete();
      end
    end

    // Request raised in a ph==0 cycle must be granted in the following cycle.
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (cyc % 2 != 0 && n < 4);
    raise_cyc = cyc;
    v = '{0, 1'b0, 32'h1234_5670, 32'h0, 1'b1, 32'hDEAD_BEEF, 4};
    push_vec(v);
    drive(0);
    wait_drain("t4", 40);
    chk("t4_grant_cycle", 64'(last_gnt_cyc[0]), 64'(raise_cyc + 1));

    // Reset one cycle after a grant discards the in-flight op.
    n0 = n_gnt;
    v  = '{0, 1'b0, 32'h1000_0040, 32'h0, 1'b0, 32'h0, 5};
    push_vec(v);
    n = 0;
    while (n_gnt == n0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("t6_grant_seen", 64'(n_gnt - n0), 64'd1);
    rst = 1'b1;
    sb.delete();
    q0.delete();
    #1;
    chk_reset_outputs("t6_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    v = '{1, 1'b1, 32'h0000_0008, 32'h5A5A_A5A5, 1'b1, 32'h5A5A_A5A5, 6};
    push_vec(v);
    wait_drain("t6_after_reset", 40);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
